// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM/IO bus controller for instruction fetch and load/store requests
// Optional feature macro: IO_STALL_EN (hold IO-space store bytes while the UART TX buffer is full)
module mem_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        rdy,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if2mc_valid,
    input  logic [31:0] if2mc_pc,
    output logic        instr_mc2if_arrived,
    output logic [31:0] instr_mc2if,
    input  logic        lsb2mc_valid,
    input  logic        lsb2mc_wr,
    input  logic [31:0] lsb2mc_addr,
    input  logic [1:0]  lsb2mc_size,
    input  logic [31:0] lsb2mc_data,
    output logic        mc2lsb_done,
    output logic [31:0] mc2lsb_data,
    input  logic        flush
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, STORE, STALL} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  n_q, n_d;
    logic [31:0] data_q, data_d;
    logic [31:0] res_q, res_d;
    logic        io_q, io_d;
    logic [7:0]  hold_din_q, hold_din_d;
    logic        hold_vld_q, hold_vld_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        arrived_q, arrived_d;
    logic [31:0] instr_q, instr_d;
    logic        done_q, done_d;
    logic [31:0] ldata_q, ldata_d;

    logic        io_block;
    logic [2:0]  size_bytes;
    logic [7:0]  din;
    logic [1:0]  rd_idx;
    logic [31:0] res_cap;
    logic [7:0]  wr_byte;

`ifdef IO_STALL_EN
    assign io_block = io_buffer_full;
`else
    assign io_block = 1'b0;
    logic unused_io;
    assign unused_io = io_buffer_full;
`endif

    always_comb begin
        case (lsb2mc_size)
            2'd0:    size_bytes = 3'd1;
            2'd1:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    end

    // A byte that arrived during a rdy stall is kept so the resumed cycle still sees it.
    assign din    = hold_vld_q ? hold_din_q : mem_din;
    assign rd_idx = cnt_q[1:0] - 2'd1;
    assign wr_byte = data_q[{cnt_q[1:0], 3'b000} +: 8];

    always_comb begin
        res_cap = res_q;
        res_cap[{rd_idx, 3'b000} +: 8] = din;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        data_d     = data_q;
        res_d      = res_q;
        io_d       = io_q;
        hold_din_d = hold_din_q;
        hold_vld_d = hold_vld_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = 1'b0;
        arrived_d  = 1'b0;
        instr_d    = instr_q;
        done_d     = 1'b0;
        ldata_d    = ldata_q;

        if (!rdy) begin
            if (!hold_vld_q) begin
                hold_din_d = mem_din;
                hold_vld_d = 1'b1;
            end
        end else begin
            hold_vld_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (!flush) begin
                        if (lsb2mc_valid) begin
                            mem_a_d = lsb2mc_addr;
                            n_d     = size_bytes;
                            data_d  = lsb2mc_data;
                            res_d   = 32'd0;
                            cnt_d   = 3'd0;
                            io_d    = (lsb2mc_addr[17:16] == 2'b11);
                            if (!lsb2mc_wr) begin
                                state_d = LOAD;
                            end else if ((lsb2mc_addr[17:16] == 2'b11) && io_block) begin
                                state_d = STALL;
                            end else begin
                                state_d    = STORE;
                                mem_dout_d = lsb2mc_data[7:0];
                                mem_wr_d   = 1'b1;
                                cnt_d      = 3'd1;
                            end
                        end else if (if2mc_valid) begin
                            mem_a_d = if2mc_pc;
                            n_d     = 3'd4;
                            res_d   = 32'd0;
                            cnt_d   = 3'd0;
                            io_d    = 1'b0;
                            state_d = FETCH;
                        end
                    end
                end
                FETCH, LOAD: begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        // cnt counts addresses issued; byte cnt-1 is on mem_din now.
                        if (cnt_q != 3'd0) begin
                            res_d = res_cap;
                        end
                        if (cnt_q == n_q) begin
                            state_d = IDLE;
                            if (state_q == FETCH) begin
                                arrived_d = 1'b1;
                                instr_d   = res_cap;
                            end else begin
                                done_d  = 1'b1;
                                ldata_d = res_cap;
                            end
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                            if (cnt_q + 3'd1 < n_q) begin
                                mem_a_d = mem_a_q + 32'd1;
                            end
                        end
                    end
                end
                STORE: begin
                    if (cnt_q == n_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (io_q && io_block) begin
                        state_d = STALL;
                        mem_a_d = mem_a_q + 32'd1;
                    end else begin
                        mem_a_d    = mem_a_q + 32'd1;
                        mem_dout_d = wr_byte;
                        mem_wr_d   = 1'b1;
                        cnt_d      = cnt_q + 3'd1;
                    end
                end
                STALL: begin
                    if (!io_block) begin
                        state_d    = STORE;
                        mem_dout_d = wr_byte;
                        mem_wr_d   = 1'b1;
                        cnt_d      = cnt_q + 3'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            n_q        <= 3'd0;
            data_q     <= 32'd0;
            res_q      <= 32'd0;
            io_q       <= 1'b0;
            hold_din_q <= 8'd0;
            hold_vld_q <= 1'b0;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            arrived_q  <= 1'b0;
            instr_q    <= 32'd0;
            done_q     <= 1'b0;
            ldata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            data_q     <= data_d;
            res_q      <= res_d;
            io_q       <= io_d;
            hold_din_q <= hold_din_d;
            hold_vld_q <= hold_vld_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            arrived_q  <= arrived_d;
            instr_q    <= instr_d;
            done_q     <= done_d;
            ldata_q    <= ldata_d;
        end
    end

    assign mem_a               = mem_a_q;
    assign mem_dout            = mem_dout_q;
    assign mem_wr              = mem_wr_q;
    assign instr_mc2if_arrived = arrived_q;
    assign instr_mc2if         = instr_q;
    assign mc2lsb_done         = done_q;
    assign mc2lsb_data         = ldata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed vector bench for mem_ctrl with a byte-wide RAM model
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset, rdy, io_buffer_full, flush;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if2mc_valid;
    logic [31:0] if2mc_pc;
    logic        instr_mc2if_arrived;
    logic [31:0] instr_mc2if;
    logic        lsb2mc_valid, lsb2mc_wr;
    logic [31:0] lsb2mc_addr, lsb2mc_data;
    logic [1:0]  lsb2mc_size;
    logic        mc2lsb_done;
    logic [31:0] mc2lsb_data;

    int checks = 0;
    int failures = 0;

    logic [7:0] ram [0:4095];

    mem_ctrl dut (
        .clk(clk), .reset(reset), .rdy(rdy),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if2mc_valid(if2mc_valid), .if2mc_pc(if2mc_pc),
        .instr_mc2if_arrived(instr_mc2if_arrived), .instr_mc2if(instr_mc2if),
        .lsb2mc_valid(lsb2mc_valid), .lsb2mc_wr(lsb2mc_wr), .lsb2mc_addr(lsb2mc_addr),
        .lsb2mc_size(lsb2mc_size), .lsb2mc_data(lsb2mc_data),
        .mc2lsb_done(mc2lsb_done), .mc2lsb_data(mc2lsb_data),
        .flush(flush)
    );

    always #5 clk = ~clk;

    // RAM: write on mem_wr, read data registered (valid the cycle after the address).
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
            ram[12'h000] <= 8'h01; ram[12'h001] <= 8'h02; ram[12'h002] <= 8'h03; ram[12'h003] <= 8'h04;
            ram[12'h010] <= 8'h11; ram[12'h011] <= 8'h22; ram[12'h012] <= 8'h33; ram[12'h013] <= 8'h44;
            ram[12'h040] <= 8'h78; ram[12'h041] <= 8'h56; ram[12'h042] <= 8'h34; ram[12'h043] <= 8'h12;
            ram[12'h100] <= 8'h13; ram[12'h101] <= 8'h05; ram[12'h102] <= 8'hA0; ram[12'h103] <= 8'h00;
            ram[12'h200] <= 8'hFF; ram[12'hFFF] <= 8'hAB;
        end else if (mem_wr) begin
            ram[mem_a[11:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[11:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // kind: 0 = fetch, 1 = load, 2 = store. Returns pulse cycle relative to T (-1 on timeout).
    task automatic do_req(input int kind, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata, output int lat, output logic [31:0] data);
        int n;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        if (kind == 0) begin
            if2mc_valid = 1'b1; if2mc_pc = addr;
        end else begin
            lsb2mc_valid = 1'b1; lsb2mc_wr = (kind == 2); lsb2mc_addr = addr;
            lsb2mc_size = size; lsb2mc_data = wdata;
        end
        lat = -1; data = 32'd0;
        for (int j = 1; j <= 30; j++) begin
            tick();
            if (j <= n) begin
                chk("bus_addr", mem_a, addr + 32'(j - 1));
                chk("bus_wr", 32'(mem_wr), 32'(kind == 2));
                if (kind == 2) chk("bus_dout", 32'(mem_dout), (wdata >> (8 * (j - 1))) & 32'hFF);
            end
            if ((kind == 0) ? instr_mc2if_arrived : mc2lsb_done) begin
                lat = j;
                data = (kind == 0) ? instr_mc2if : mc2lsb_data;
                break;
            end
        end
        if2mc_valid = 1'b0;
        lsb2mc_valid = 1'b0;
    endtask

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int lat, c1, c2;
        logic [31:0] d, d1, d2;

        vecs[0]  = '{0, 32'h0000_0100, 2'd2, 32'h0,         6, 32'h00A0_0513};
        vecs[1]  = '{1, 32'h0000_0200, 2'd0, 32'h0,         3, 32'h0000_00FF};
        vecs[2]  = '{1, 32'h0000_0040, 2'd1, 32'h0,         4, 32'h0000_5678};
        vecs[3]  = '{1, 32'h0000_0040, 2'd2, 32'h0,         6, 32'h1234_5678};
        vecs[4]  = '{2, 32'h0000_0010, 2'd1, 32'hDEAD_BEEF, 3, 32'h0};
        vecs[5]  = '{1, 32'h0000_0010, 2'd2, 32'h0,         6, 32'h4433_BEEF};
        vecs[6]  = '{2, 32'h0000_0041, 2'd0, 32'h0000_00AA, 2, 32'h0};
        vecs[7]  = '{1, 32'h0000_0040, 2'd2, 32'h0,         6, 32'h1234_AA78};
        vecs[8]  = '{1, 32'h0000_0100, 2'd3, 32'h0,         6, 32'h00A0_0513};
        vecs[9]  = '{2, 32'h0000_0080, 2'd2, 32'hCAFE_F00D, 5, 32'h0};
        vecs[10] = '{1, 32'h0000_0080, 2'd2, 32'h0,         6, 32'hCAFE_F00D};
        vecs[11] = '{1, 32'hFFFF_FFFF, 2'd2, 32'h0,         6, 32'h0302_01AB};
        vecs[12] = '{1, 32'h0000_0102, 2'd0, 32'h0,         3, 32'h0000_00A0};

        reset = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
        if2mc_valid = 1'b0; if2mc_pc = 32'h0;
        lsb2mc_valid = 1'b0; lsb2mc_wr = 1'b0; lsb2mc_addr = 32'h0;
        lsb2mc_size = 2'd0; lsb2mc_data = 32'h0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_dout", 32'(mem_dout), 32'h0);
        chk("rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("rst_arrived", 32'(instr_mc2if_arrived), 32'h0);
        chk("rst_instr", instr_mc2if, 32'h0);
        chk("rst_done", 32'(mc2lsb_done), 32'h0);
        chk("rst_ldata", mc2lsb_data, 32'h0);

        for (int i = 0; i < 13; i++) begin
            do_req(vecs[i].kind, vecs[i].addr, vecs[i].size, vecs[i].wdata, lat, d);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            if (vecs[i].kind != 2) chk($sformatf("vec%0d_data", i), d, vecs[i].exp);
        end

        // Simultaneous fetch and byte load: LSB served first, fetch sampled in the done cycle.
        if2mc_valid = 1'b1; if2mc_pc = 32'h0;
        lsb2mc_valid = 1'b1; lsb2mc_wr = 1'b0; lsb2mc_addr = 32'h200; lsb2mc_size = 2'd0;
        c1 = -1; c2 = -1; d1 = 32'h0; d2 = 32'h0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (mc2lsb_done && c1 < 0) begin c1 = j; d1 = mc2lsb_data; lsb2mc_valid = 1'b0; end
            if (instr_mc2if_arrived) begin c2 = j; d2 = instr_mc2if; break; end
        end
        if2mc_valid = 1'b0; lsb2mc_valid = 1'b0;
        chk("arb_done_cycle", 32'(c1), 32'd3);
        chk("arb_load_data", d1, 32'h0000_00FF);
        chk("arb_arrived_cycle", 32'(c2), 32'd9);
        chk("arb_fetch_data", d2, 32'h0403_0201);

        // Flush in T+3 aborts the fetch with the address frozen and no pulse.
        if2mc_valid = 1'b1; if2mc_pc = 32'h100;
        tick(); tick(); tick();
        chk("flush_addr_t3", mem_a, 32'h102);
        flush = 1'b1; if2mc_valid = 1'b0;
        tick();
        flush = 1'b0;
        chk("flush_wr_t4", 32'(mem_wr), 32'h0);
        chk("flush_addr_t4", mem_a, 32'h102);
        c1 = 0;
        for (int j = 0; j < 8; j++) begin
            if (instr_mc2if_arrived) c1++;
            tick();
        end
        chk("flush_no_pulse", 32'(c1), 32'd0);
        chk("flush_addr_held", mem_a, 32'h102);
        do_req(0, 32'h100, 2'd2, 32'h0, lat, d);
        chk("post_flush_latency", 32'(lat), 32'd6);
        chk("post_flush_data", d, 32'h00A0_0513);

        // rdy low for three cycles mid-load delays completion by three.
        lsb2mc_valid = 1'b1; lsb2mc_wr = 1'b0; lsb2mc_addr = 32'h40; lsb2mc_size = 2'd2;
        c1 = -1; d1 = 32'h0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (j == 2) rdy = 1'b0;
            if (j == 5) rdy = 1'b1;
            if (mc2lsb_done) begin c1 = j; d1 = mc2lsb_data; break; end
        end
        rdy = 1'b1; lsb2mc_valid = 1'b0;
        chk("rdy_latency", 32'(c1), 32'd9);
        chk("rdy_data", d1, 32'h1234_AA78);

        // Reset in the middle of a word store clears every output next cycle.
        lsb2mc_valid = 1'b1; lsb2mc_wr = 1'b1; lsb2mc_addr = 32'h80;
        lsb2mc_size = 2'd2; lsb2mc_data = 32'h1122_3344;
        tick();
        chk("rst_store_wr_t1", 32'(mem_wr), 32'h1);
        tick();
        reset = 1'b1; lsb2mc_valid = 1'b0;
        tick();
        chk("rstmid_mem_a", mem_a, 32'h0);
        chk("rstmid_mem_dout", 32'(mem_dout), 32'h0);
        chk("rstmid_mem_wr", 32'(mem_wr), 32'h0);
        chk("rstmid_instr", instr_mc2if, 32'h0);
        chk("rstmid_ldata", mc2lsb_data, 32'h0);
        chk("rstmid_pulses", {30'h0, instr_mc2if_arrived, mc2lsb_done}, 32'h0);
        reset = 1'b0;
        tick();

`ifdef IO_STALL_EN
        // IO store held off while the TX buffer is full for four cycles.
        io_buffer_full = 1'b1;
        lsb2mc_valid = 1'b1; lsb2mc_wr = 1'b1; lsb2mc_addr = 32'h0003_0800;
        lsb2mc_size = 2'd0; lsb2mc_data = 32'h0000_005A;
        c1 = -1;
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (j == 4) io_buffer_full = 1'b0;
            if (j <= 4) chk($sformatf("io_stall_wr_t%0d", j), 32'(mem_wr), 32'h0);
            if (j == 5) begin
                chk("io_write_wr", 32'(mem_wr), 32'h1);
                chk("io_write_addr", mem_a, 32'h0003_0800);
                chk("io_write_dout", 32'(mem_dout), 32'h5A);
            end
            if (mc2lsb_done) begin c1 = j; break; end
        end
        lsb2mc_valid = 1'b0; io_buffer_full = 1'b0;
        chk("io_done_cycle", 32'(c1), 32'd6);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
